i2c_register_bank: RTL and testbench
====================================

I2C_REGISTER_BANK -- requirements
Module: i2c_register_bank

Interface
REQ-001 Parameter: NUM_REGS, default 8, number of 8-bit registers; SHALL be a power of two, 2..256.
REQ-002 Parameter: ADDR_W, default 3, pointer width; SHALL equal log2(NUM_REGS).
REQ-003 Port: clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Port: i2c_start_stb  in  1  one-cycle pulse: address match after (repeated) START.
REQ-006 Port: i2c_stop_stb  in  1  one-cycle pulse: STOP seen.
REQ-007 Port: i2c_data_rx  in  8  byte received from master.
REQ-008 Port: i2c_data_rx_valid_stb  in  1  one-cycle pulse qualifying i2c_data_rx.
REQ-009 Port: i2c_tx_done_stb  in  1  one-cycle pulse: byte on i2c_data_tx was shifted out and ACKed.
REQ-010 Port: i2c_data_tx  out  8  byte offered to the slave for the next read.
REQ-011 Port: status_in  in  8  external status byte.
REQ-012 Port: regs_flat  out  NUM_REGS*8  all registers; register k at bits [8k+7:8k].
REQ-013 Port: reg_wr_stb  out  1  one-cycle pulse per register write.
REQ-014 Port: reg_wr_addr  out  ADDR_W  index written when reg_wr_stb is high.

Function
REQ-015 FSM states: IDLE, PTR, DATA.
REQ-016 Any state, i2c_start_stb -> PTR next cycle; pointer unchanged.
REQ-017 Any state, i2c_stop_stb -> IDLE next cycle; pointer retained.
REQ-018 PTR + rx_valid -> ptr <= i2c_data_rx[ADDR_W-1:0] (upper bits ignored); state -> DATA; no register write.
REQ-019 DATA + rx_valid -> regs[ptr] <= i2c_data_rx; ptr <= ptr+1 mod NUM_REGS; reg_wr_stb=1 and reg_wr_addr=old ptr in the following cycle.
REQ-020 IDLE + rx_valid -> byte ignored; no state change.
REQ-021 i2c_tx_done_stb in PTR or DATA -> ptr <= ptr+1 mod NUM_REGS; state unchanged; ignored in IDLE.
REQ-022 i2c_data_tx SHALL be registered: equals regs[ptr] one cycle after any change to ptr or to regs[ptr].
REQ-023 Pointer wrap: NUM_REGS-1 -> 0, for both writes and reads.
REQ-024 Priority in one cycle: rst > i2c_start_stb > i2c_stop_stb > rx_valid > tx_done; lower-priority events in that cycle are dropped.
REQ-025 regs_flat SHALL reflect register contents combinationally from the register array (no added latency).

Reset
REQ-026 On rst: state=IDLE, ptr=0, all regs=0x00, i2c_data_tx=0x00, reg_wr_stb=0, reg_wr_addr=0.
REQ-027 rst mid-transaction SHALL abandon it; subsequent bytes are ignored until the next i2c_start_stb.

Configuration
REQ-028 Macro I2C_REGBANK_STATUS_EN defined: register NUM_REGS-1 is read-only and reads status_in, sampled into i2c_data_tx per REQ-022; writes to it still advance ptr but neither store data nor assert reg_wr_stb.
REQ-029 Macro undefined: register NUM_REGS-1 is an ordinary read/write register; status_in is unused.

Structure
REQ-030 Shared package i2c_regbank_pkg SHALL hold the FSM state encoding and the default NUM_REGS/ADDR_W constants.
REQ-031 Single module; no sub-module.

Verification
REQ-032 start, rx 0x02, rx 0xAA, rx 0xBB, stop -> regs[2]=0xAA, regs[3]=0xBB; two reg_wr_stb pulses, addr 2 then 3; ptr=4.
REQ-033 regs[6]=0x11, regs[7]=0x22, regs[0]=0x33; start, rx 0x06, stop, start, tx_done x2 -> i2c_data_tx sequence 0x11, 0x22, 0x33.
REQ-034 start, rx 0xFF (NUM_REGS=8), rx 0x5A, rx 0xA5 -> ptr=7; regs[7]=0x5A (macro undefined); regs[0]=0xA5.
REQ-035 rx_valid 0x44 with no prior start -> no write, no reg_wr_stb; i2c_start_stb and rx_valid in the same cycle -> byte dropped; state=PTR.
REQ-036 Macro defined, status_in=0x81: start, rx 0x07, rx 0x00 -> no reg_wr_stb; i2c_data_tx=0x81 while ptr=7; ptr wraps to 0.
REQ-037 rst asserted after pointer byte 0x03 -> state IDLE, ptr 0, all regs 0; next rx 0x99 ignored.

Source files
------------

// File: rtl/i2c_regbank_pkg.sv
// Shared constants for the I2C register bank: default geometry and FSM state encoding.
package i2c_regbank_pkg;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_ADDR_W   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PTR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/i2c_register_bank.sv
// Byte-wide register bank behind an I2C slave: first byte after START sets the pointer,
// later bytes write and auto-increment. Optional I2C_REGBANK_STATUS_EN maps status_in onto the top register.
module i2c_register_bank
    import i2c_regbank_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2c_start_stb,
    input  logic                  i2c_stop_stb,
    input  logic [7:0]            i2c_data_rx,
    input  logic                  i2c_data_rx_valid_stb,
    input  logic                  i2c_tx_done_stb,
    output logic [7:0]            i2c_data_tx,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  reg_wr_stb,
    output logic [ADDR_W-1:0]     reg_wr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_regs [NUM_REGS];
    logic [7:0]        r_data_tx;
    logic              r_wr_stb;
    logic [ADDR_W-1:0] r_wr_addr;

    logic              w_wr_blocked;
    logic [7:0]        w_rd_byte;
    logic [ADDR_W-1:0] w_ptr_inc;

    assign w_ptr_inc = r_ptr + ADDR_W'(1);

`ifdef I2C_REGBANK_STATUS_EN
    // Top register is a read-only window onto status_in; its storage is never written.
    assign w_wr_blocked = (r_ptr == LAST_IDX);
    assign w_rd_byte    = (r_ptr == LAST_IDX) ? status_in : r_regs[r_ptr];
`else
    logic w_unused_status;
    logic w_unused_last;
    assign w_unused_status = ^status_in;
    assign w_unused_last   = ^LAST_IDX;
    assign w_wr_blocked    = 1'b0;
    assign w_rd_byte       = r_regs[r_ptr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_data_tx <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_wr_stb  <= 1'b0;
            r_data_tx <= w_rd_byte;
            // Only the highest-priority event of a cycle takes effect.
            if (i2c_start_stb) begin
                r_state <= ST_PTR;
            end else if (i2c_stop_stb) begin
                r_state <= ST_IDLE;
            end else if (i2c_data_rx_valid_stb) begin
                if (r_state == ST_PTR) begin
                    r_ptr   <= i2c_data_rx[ADDR_W-1:0];
                    r_state <= ST_DATA;
                end else if (r_state == ST_DATA) begin
                    if (!w_wr_blocked) begin
                        r_regs[r_ptr] <= i2c_data_rx;
                        r_wr_stb      <= 1'b1;
                        r_wr_addr     <= r_ptr;
                    end
                    r_ptr <= w_ptr_inc;
                end
            end else if (i2c_tx_done_stb) begin
                if (r_state != ST_IDLE) begin
                    r_ptr <= w_ptr_inc;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = r_regs[g];
    end

    assign i2c_data_tx = r_data_tx;
    assign reg_wr_stb  = r_wr_stb;
    assign reg_wr_addr = r_wr_addr;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Randomized and directed bench for i2c_register_bank against a transaction-level model.
module tb_i2c_register_bank;

    localparam int N  = 8;
    localparam int AW = 3;

`ifdef I2C_REGBANK_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           i2c_start_stb;
    logic           i2c_stop_stb;
    logic [7:0]     i2c_data_rx;
    logic           i2c_data_rx_valid_stb;
    logic           i2c_tx_done_stb;
    logic [7:0]     i2c_data_tx;
    logic [7:0]     status_in;
    logic [N*8-1:0] regs_flat;
    logic           reg_wr_stb;
    logic [AW-1:0]  reg_wr_addr;

    always #5 clk = ~clk;

    i2c_register_bank #(.NUM_REGS(N), .ADDR_W(AW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i2c_start_stb         (i2c_start_stb),
        .i2c_stop_stb          (i2c_stop_stb),
        .i2c_data_rx           (i2c_data_rx),
        .i2c_data_rx_valid_stb (i2c_data_rx_valid_stb),
        .i2c_tx_done_stb       (i2c_tx_done_stb),
        .i2c_data_tx           (i2c_data_tx),
        .status_in             (status_in),
        .regs_flat             (regs_flat),
        .reg_wr_stb            (reg_wr_stb),
        .reg_wr_addr           (reg_wr_addr)
    );

    // Transaction-level model: bus phase, pointer and register contents.
    localparam int M_IDLE = 0, M_PTR = 1, M_DATA = 2;
    logic [7:0]    m_regs [N];
    int            m_ptr;
    int            m_phase;
    logic [AW+7:0] exp_q [$];
    logic [AW+7:0] mon_exp;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string name, input logic [N*8-1:0] act, input logic [N*8-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read();
        if (STATUS_EN && m_ptr == N - 1) return status_in;
        return m_regs[m_ptr];
    endfunction

    function automatic logic [N*8-1:0] m_flat();
        logic [N*8-1:0] f;
        for (int k = 0; k < N; k++) f[8*k +: 8] = m_regs[k];
        return f;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        m_ptr   = 0;
        m_phase = M_IDLE;
        exp_q.delete();
    endtask

    // One bus cycle with the given strobes; called at a falling edge, returns at the next one.
    task automatic step(input bit st, input bit sp, input bit rv, input logic [7:0] d, input bit td);
        logic [7:0] exp_tx;
        i2c_start_stb         = st;
        i2c_stop_stb          = sp;
        i2c_data_rx_valid_stb = rv;
        i2c_data_rx           = d;
        i2c_tx_done_stb       = td;
        exp_tx = m_read();
        if (st) begin
            m_phase = M_PTR;
        end else if (sp) begin
            m_phase = M_IDLE;
        end else if (rv) begin
            if (m_phase == M_PTR) begin
                m_ptr   = int'(d) % N;
                m_phase = M_DATA;
            end else if (m_phase == M_DATA) begin
                if (!(STATUS_EN && m_ptr == N - 1)) begin
                    m_regs[m_ptr] = d;
                    exp_q.push_back({AW'(m_ptr), d});
                end
                m_ptr = (m_ptr + 1) % N;
            end
        end else if (td && m_phase != M_IDLE) begin
            m_ptr = (m_ptr + 1) % N;
        end
        @(negedge clk);
        i2c_start_stb         = 1'b0;
        i2c_stop_stb          = 1'b0;
        i2c_data_rx_valid_stb = 1'b0;
        i2c_data_rx           = 8'h00;
        i2c_tx_done_stb       = 1'b0;
        chk("data_tx", {{(N*8-8){1'b0}}, i2c_data_tx}, {{(N*8-8){1'b0}}, exp_tx});
        chk("regs_flat", regs_flat, m_flat());
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rx(input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        chk("rst_data_tx", {{(N*8-8){1'b0}}, i2c_data_tx}, '0);
        chk("rst_regs", regs_flat, '0);
        chk("rst_wr_stb", {{(N*8-1){1'b0}}, reg_wr_stb}, '0);
        chk("rst_wr_addr", {{(N*8-AW){1'b0}}, reg_wr_addr}, '0);
    endtask

    // Write monitor: each strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (!rst && reg_wr_stb) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr %0d, expected no write", reg_wr_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("wr_addr_data", {{(N*8-AW-8){1'b0}}, reg_wr_addr, regs_flat[8*reg_wr_addr +: 8]},
                    {{(N*8-AW-8){1'b0}}, mon_exp});
            end
        end
    end

    initial begin
        rst                   = 1'b1;
        i2c_start_stb         = 1'b0;
        i2c_stop_stb          = 1'b0;
        i2c_data_rx           = 8'h00;
        i2c_data_rx_valid_stb = 1'b0;
        i2c_tx_done_stb       = 1'b0;
        status_in             = 8'h81;
        m_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Pointer then two writes.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        rx(8'h02); rx(8'hAA); rx(8'hBB);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle();
        chk("w2_reg2", {{(N*8-8){1'b0}}, regs_flat[23:16]}, {{(N*8-8){1'b0}}, 8'hAA});
        chk("w2_reg3", {{(N*8-8){1'b0}}, regs_flat[31:24]}, {{(N*8-8){1'b0}}, 8'hBB});

        // Preload 6,7,0 then read back across the wrap with tx_done.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        rx(8'h06); rx(8'h11); rx(8'h22); rx(8'h33);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        rx(8'h06);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        idle();
        chk("rd_seq0", {{(N*8-8){1'b0}}, i2c_data_tx}, {{(N*8-8){1'b0}}, 8'h11});
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
`ifndef I2C_REGBANK_STATUS_EN
        chk("rd_seq1", {{(N*8-8){1'b0}}, i2c_data_tx}, {{(N*8-8){1'b0}}, 8'h22});
`endif
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle();
        chk("rd_seq2", {{(N*8-8){1'b0}}, i2c_data_tx}, {{(N*8-8){1'b0}}, 8'h33});
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Pointer upper bits ignored, write wraps 7 -> 0.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        rx(8'hFF); rx(8'h5A); rx(8'hA5);
        idle();
        chk("wrap_reg0", {{(N*8-8){1'b0}}, regs_flat[7:0]}, {{(N*8-8){1'b0}}, 8'hA5});
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Bytes with no transaction open, and a byte colliding with START.
        rx(8'h44);
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
        rx(8'h01); rx(8'h77);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

`ifdef I2C_REGBANK_STATUS_EN
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        rx(8'h07);
        idle();
        chk("status_tx", {{(N*8-8){1'b0}}, i2c_data_tx}, {{(N*8-8){1'b0}}, 8'h81});
        rx(8'h00); rx(8'h3C);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
`endif

        // Reset mid-transaction, then a stray byte.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        rx(8'h03);
        do_reset();
        rx(8'h99);
        idle();

        // Random traffic including colliding strobes and occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0);
            end
        end
        idle();
        idle();
        chk("wr_q_drained", {{(N*8-32){1'b0}}, 32'(exp_q.size())}, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
